// File: rtl/mux_2to1_arbiter.sv
// mux_2to1_arbiter: round-robin 2:1 arbiter feeding a single registered output slot
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   a_data/a_valid/a_ready   requester A handshake
//   b_data/b_valid/b_ready   requester B handshake
//   y_data/y_valid/y_ready   registered output handshake
//   sel                current or most recent grant (0 = A, 1 = B)
//   busy               FSM not idle or output slot occupied
// Optional macro MUX_ARB_LAST_EN adds a_last/b_last/y_last; a grant then
// persists until a last word is accepted.
module mux_2to1_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MUX_ARB_LAST_EN
  input  logic             a_last,
  input  logic             b_last,
  output logic             y_last,
`endif
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
  state_t state;
  logic last_b, free, acc_a, acc_b, acc, leave;
  assign free = !y_valid | y_ready;
  assign a_ready = (state == GRANT_A) & free;
  assign b_ready = (state == GRANT_B) & free;
  assign acc_a = a_valid & a_ready;
  assign acc_b = b_valid & b_ready;
  assign acc = acc_a | acc_b;
  assign busy = (state != IDLE) | y_valid;
`ifdef MUX_ARB_LAST_EN
  // grant survives valid gaps; only an accepted last word releases it
  assign leave = acc & (acc_a ? a_last : b_last);
`else
  // any accept, or the granted requester withdrawing, releases the grant
  assign leave = acc | ((state == GRANT_A) & !a_valid) | ((state == GRANT_B) & !b_valid);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_b  <= 1'b1;
      sel     <= 1'b0;
      y_valid <= 1'b0;
      y_data  <= '0;
`ifdef MUX_ARB_LAST_EN
      y_last  <= 1'b0;
`endif
    end else begin
      if (state == IDLE) begin
        // tie goes to whoever was not granted last
        if (a_valid | b_valid)
          state <= (a_valid & (!b_valid | last_b)) ? GRANT_A : GRANT_B;
      end else if (leave) begin
        state <= IDLE;
      end
      if (acc) begin
        y_data  <= acc_a ? a_data : b_data;
        y_valid <= 1'b1;
        sel     <= acc_b;
        last_b  <= acc_b;
`ifdef MUX_ARB_LAST_EN
        y_last  <= acc_a ? a_last : b_last;
`endif
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// tb_mux_2to1_arbiter: directed self-checking bench for mux_2to1_arbiter
module tb_mux_2to1_arbiter;
  logic clk = 0, rst = 0;
  logic [7:0] a_data = 0, b_data = 0, y_data;
  logic a_valid = 0, b_valid = 0, y_ready = 0;
  logic a_ready, b_ready, y_valid, sel, busy;
`ifdef MUX_ARB_LAST_EN
  logic a_last = 0, b_last = 0, y_last;
`endif
  int n_chk = 0, n_fail = 0;

  mux_2to1_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
`ifdef MUX_ARB_LAST_EN
    .a_last(a_last), .b_last(b_last), .y_last(y_last),
`endif
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 0; b_valid = 0; y_ready = 0; a_data = 0; b_data = 0;
`ifdef MUX_ARB_LAST_EN
    a_last = 0; b_last = 0;
`endif
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid got %b want 0", y_valid); end
    n_chk++; if (y_data !== 8'd0) begin n_fail++; $display("FAIL reset_y_data got %0d want 0", y_data); end
    n_chk++; if ({a_ready, b_ready, busy, sel} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 0000", {a_ready, b_ready, busy, sel}); end
  endtask

  task automatic test_single();
    do_reset();
    a_data = 8; a_valid = 1; y_ready = 1;
    #1;
    n_chk++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL single_c0_ready got %b want 0", a_ready); end
    step();
    n_chk++; if (a_ready !== 1'b1 || y_valid !== 1'b0) begin n_fail++; $display("FAIL single_c1 got ready=%b yv=%b want 1 0", a_ready, y_valid); end
    step();
    n_chk++; if (y_valid !== 1'b1 || y_data !== 8'd8 || sel !== 1'b0) begin n_fail++; $display("FAIL single_c2 got yv=%b y=%0d sel=%b want 1 8 0", y_valid, y_data, sel); end
    a_valid = 0;
    step();
    n_chk++; if (y_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_c3 got yv=%b busy=%b want 0 0", y_valid, busy); end
  endtask

  task automatic test_alternate();
    logic [7:0] got_d [4];
    logic got_s [4];
    logic [7:0] exp_d [4];
    int cnt = 0;
    exp_d[0] = 8; exp_d[1] = 16; exp_d[2] = 8; exp_d[3] = 16;
    do_reset();
    a_data = 8; b_data = 16; a_valid = 1; b_valid = 1; y_ready = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (y_valid && cnt < 4) begin got_d[cnt] = y_data; got_s[cnt] = sel; cnt++; end
    end
    a_valid = 0; b_valid = 0;
    n_chk++; if (cnt !== 4) begin n_fail++; $display("FAIL alt_count got %0d want 4", cnt); end
    for (int i = 0; i < cnt; i++) begin
      n_chk++; if (got_d[i] !== exp_d[i] || got_s[i] !== i[0]) begin n_fail++; $display("FAIL alt_word%0d got %0d sel=%b want %0d sel=%b", i, got_d[i], got_s[i], exp_d[i], i[0]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_data = 8; a_valid = 1; y_ready = 0;
    step();
    step();
    a_data = 24;
    n_chk++; if (y_valid !== 1'b1 || y_data !== 8'd8) begin n_fail++; $display("FAIL bp_first got yv=%b y=%0d want 1 8", y_valid, y_data); end
    step();
    step();
    n_chk++; if (a_ready !== 1'b0 || y_data !== 8'd8 || y_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold got ready=%b y=%0d yv=%b want 0 8 1", a_ready, y_data, y_valid); end
    y_ready = 1;
    #1;
    n_chk++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", a_ready); end
    step();
    n_chk++; if (y_valid !== 1'b1 || y_data !== 8'd24) begin n_fail++; $display("FAIL bp_drain_accept got yv=%b y=%0d want 1 24", y_valid, y_data); end
    a_valid = 0;
    step();
    n_chk++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", y_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    b_data = 16; b_valid = 1; y_ready = 0;
    step();
    step();
    n_chk++; if (y_valid !== 1'b1 || sel !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got yv=%b sel=%b want 1 1", y_valid, sel); end
    rst = 1;
    step();
    n_chk++; if ({y_valid, busy, sel} !== 3'b000) begin n_fail++; $display("FAIL rmid_reset got %b want 000", {y_valid, busy, sel}); end
    rst = 0;
    a_data = 8; a_valid = 1; y_ready = 1;
    step();
    step();
    n_chk++; if (y_valid !== 1'b1 || y_data !== 8'd8 || sel !== 1'b0) begin n_fail++; $display("FAIL rmid_tie got yv=%b y=%0d sel=%b want 1 8 0", y_valid, y_data, sel); end
    a_valid = 0; b_valid = 0;
    step();
  endtask

`ifdef MUX_ARB_LAST_EN
  task automatic test_last();
    logic [7:0] got_d [4];
    logic got_l [4];
    logic [7:0] exp_d [4];
    logic [3:0] exp_l = 4'b1100;
    int cnt = 0, idx = 1;
    logic acc, gap = 0;
    exp_d[0] = 1; exp_d[1] = 2; exp_d[2] = 3; exp_d[3] = 16;
    do_reset();
    b_data = 16; b_last = 1; b_valid = 1; a_data = 1; a_last = 0; a_valid = 1; y_ready = 1;
    for (int i = 0; i < 30; i++) begin
      #1;
      acc = a_valid & a_ready;
      step();
      if (y_valid && cnt < 4) begin got_d[cnt] = y_data; got_l[cnt] = y_last; cnt++; end
      if (gap) begin a_valid = 1; gap = 0; end
      if (acc) begin
        if (idx == 1) begin a_valid = 0; gap = 1; a_data = 2; end
        else if (idx == 2) begin a_data = 3; a_last = 1; end
        else a_valid = 0;
        idx++;
      end
    end
    b_valid = 0;
    n_chk++; if (cnt !== 4) begin n_fail++; $display("FAIL last_count got %0d want 4", cnt); end
    for (int i = 0; i < cnt; i++) begin
      n_chk++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin n_fail++; $display("FAIL last_word%0d got %0d last=%b want %0d last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
    end
  endtask
`else
  task automatic test_drop();
    do_reset();
    b_data = 16; b_valid = 1; y_ready = 1;
    step();
    n_chk++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL drop_grant_b got %b want 1", b_ready); end
    b_valid = 0; a_data = 8; a_valid = 1;
    step();
    n_chk++; if ({y_valid, busy, b_ready} !== 3'b000) begin n_fail++; $display("FAIL drop_idle got %b want 000", {y_valid, busy, b_ready}); end
    step();
    n_chk++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL drop_grant_a got %b want 1", a_ready); end
    step();
    n_chk++; if (y_valid !== 1'b1 || y_data !== 8'd8 || sel !== 1'b0) begin n_fail++; $display("FAIL drop_word got yv=%b y=%0d sel=%b want 1 8 0", y_valid, y_data, sel); end
    a_valid = 0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_reset_mid();
`ifdef MUX_ARB_LAST_EN
    test_last();
`else
    test_drop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
